// File: rtl/fpu_addsub_seq.sv
// rtl/fpu_addsub_seq.sv - sequential floating-point add/subtract unit with sticky exception flag.
// Optional round-to-nearest-even in ROUND is enabled by defining FPU_ROUND_NEAREST_EN (truncation otherwise).
module fpu_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clock100KHz,
    input  logic                   reset,
    input  logic                   start_in,
    input  logic                   op_sub_in,
    input  logic [EXP_W+MAN_W:0]   op_A_in,
    input  logic [EXP_W+MAN_W:0]   op_B_in,
    input  logic                   clear_in,
    output logic                   busy_out,
    output logic                   done_out,
    output logic [EXP_W+MAN_W:0]   data_out,
    output logic [3:0]             status_out,
    output logic                   flags_out
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 4;
    localparam int XW = EXP_W + 2;
    localparam int CW = $clog2(M + 2);

    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
    localparam logic [CW-1:0]        SH_LIM  = CW'(M);

    localparam logic [3:0] ST_EXACT = 4'b0001;
    localparam logic [3:0] ST_OVF   = 4'b0010;
    localparam logic [3:0] ST_UNF   = 4'b0100;
    localparam logic [3:0] ST_INEX  = 4'b1000;

    typedef enum logic [2:0] {
        IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [W-1:0]          r_a;
    logic [W-1:0]          r_b;
    logic                  r_sub;
    logic signed [XW-1:0]  r_ea;
    logic signed [XW-1:0]  r_eb;
    logic [M-1:0]          r_ma;
    logic [M-1:0]          r_mb;
    logic                  r_sa;
    logic                  r_sb;
    logic [CW-1:0]         r_shcnt;
    logic [M:0]            r_sum;
    logic signed [XW-1:0]  r_exp;
    logic                  r_sign;
    logic [W-1:0]          r_data;
    logic [3:0]            r_status;
    logic                  r_flags;

    logic                  w_special;
    logic                  w_a_zero;
    logic                  w_b_zero;
    logic                  w_norm_done;
    logic                  w_inexact;
    logic                  w_carry;
    logic [MAN_W-1:0]      w_frac_rnd;
    logic signed [XW-1:0]  w_exp_rnd;
    logic [W-1:0]          w_data_rnd;
    logic [3:0]            w_status_rnd;
    logic                  w_set_flag;

    // Right shift by one, folding the dropped bit into the sticky position.
    function automatic logic [M-1:0] shr1(input logic [M-1:0] v);
        return {1'b0, v[M-1:2], v[1] | v[0]};
    endfunction

    assign w_special   = (r_a[W-2:MAN_W] == '1) || (r_b[W-2:MAN_W] == '1);
    assign w_a_zero    = (r_a[W-2:MAN_W] == '0);
    assign w_b_zero    = (r_b[W-2:MAN_W] == '0);
    assign w_norm_done = (r_sum == '0) || r_sum[M] || r_sum[M-1];

    always_ff @(posedge clock100KHz) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (start_in) w_next = UNPACK;
            UNPACK: w_next = w_special ? DONE : ALIGN;
            ALIGN:  if ((r_ea == r_eb) || (r_shcnt >= SH_LIM)) w_next = ADD;
            ADD:    w_next = NORM;
            NORM:   if (w_norm_done) w_next = ROUND;
            ROUND:  w_next = DONE;
            DONE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_inexact = |r_sum[2:0];
        w_exp_rnd = r_exp;
        w_carry   = 1'b0;
`ifdef FPU_ROUND_NEAREST_EN
        begin
            logic w_inc;
            w_inc = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
            {w_carry, w_frac_rnd} = {1'b0, r_sum[M-2:3]} + {{MAN_W{1'b0}}, w_inc};
        end
`else
        w_frac_rnd = r_sum[M-2:3];
`endif
        // A fraction carry means 1.11..1 rounded up to 10.00..0: fraction is already 0.
        if (w_carry) w_exp_rnd = r_exp + XW'(1);

        if (r_sum == '0) begin
            w_data_rnd   = '0;
            w_status_rnd = ST_EXACT;
        end else if (w_exp_rnd >= EXP_MAX) begin
            w_data_rnd   = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_status_rnd = ST_OVF;
        end else if (w_exp_rnd <= 0) begin
            w_data_rnd   = {r_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            w_status_rnd = ST_UNF;
        end else begin
            w_data_rnd   = {r_sign, w_exp_rnd[EXP_W-1:0], w_frac_rnd};
            w_status_rnd = w_inexact ? ST_INEX : ST_EXACT;
        end

        w_set_flag = ((r_state == UNPACK) && w_special) ||
                     ((r_state == ROUND) && (w_status_rnd != ST_EXACT));
    end

    always_ff @(posedge clock100KHz) begin
        if (!reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
            r_ea     <= '0;
            r_eb     <= '0;
            r_ma     <= '0;
            r_mb     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_shcnt  <= '0;
            r_sum    <= '0;
            r_exp    <= '0;
            r_sign   <= 1'b0;
            r_data   <= '0;
            r_status <= '0;
            r_flags  <= 1'b0;
        end else begin
            if (w_set_flag) begin
                r_flags <= 1'b1;
            end else if (clear_in) begin
                r_flags <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (start_in) begin
                        r_a   <= op_A_in;
                        r_b   <= op_B_in;
                        r_sub <= op_sub_in;
                    end
                end
                UNPACK: begin
                    if (w_special) begin
                        r_data   <= {r_a[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        r_status <= ST_OVF;
                    end else begin
                        r_ea    <= XW'(r_a[W-2:MAN_W]);
                        r_eb    <= XW'(r_b[W-2:MAN_W]);
                        r_ma    <= w_a_zero ? '0 : {1'b1, r_a[MAN_W-1:0], 3'b000};
                        r_mb    <= w_b_zero ? '0 : {1'b1, r_b[MAN_W-1:0], 3'b000};
                        r_sa    <= r_a[W-1];
                        r_sb    <= r_b[W-1] ^ r_sub;
                        r_shcnt <= '0;
                    end
                end
                ALIGN: begin
                    if (r_ea != r_eb) begin
                        // Past the datapath width only the sticky information survives.
                        if (r_shcnt >= SH_LIM) begin
                            if (r_ea < r_eb) begin
                                r_ma <= {{(M-1){1'b0}}, |r_ma};
                                r_ea <= r_eb;
                            end else begin
                                r_mb <= {{(M-1){1'b0}}, |r_mb};
                                r_eb <= r_ea;
                            end
                        end else begin
                            r_shcnt <= r_shcnt + CW'(1);
                            if (r_ea < r_eb) begin
                                r_ma <= shr1(r_ma);
                                r_ea <= r_ea + XW'(1);
                            end else begin
                                r_mb <= shr1(r_mb);
                                r_eb <= r_eb + XW'(1);
                            end
                        end
                    end
                end
                ADD: begin
                    r_exp <= r_ea;
                    if (r_sa == r_sb) begin
                        r_sum  <= {1'b0, r_ma} + {1'b0, r_mb};
                        r_sign <= r_sa;
                    end else if (r_ma >= r_mb) begin
                        r_sum  <= {1'b0, r_ma - r_mb};
                        r_sign <= r_sa;
                    end else begin
                        r_sum  <= {1'b0, r_mb - r_ma};
                        r_sign <= r_sb;
                    end
                end
                NORM: begin
                    if (r_sum == '0) begin
                        r_sign <= 1'b0;
                    end else if (r_sum[M]) begin
                        r_sum <= {1'b0, r_sum[M:2], r_sum[1] | r_sum[0]};
                        r_exp <= r_exp + XW'(1);
                    end else if (!r_sum[M-1]) begin
                        r_sum <= {r_sum[M-1:0], 1'b0};
                        r_exp <= r_exp - XW'(1);
                    end
                end
                ROUND: begin
                    r_data   <= w_data_rnd;
                    r_status <= w_status_rnd;
                end
                default: ;
            endcase
        end
    end

    assign busy_out   = (r_state != IDLE);
    assign done_out   = (r_state == DONE);
    assign data_out   = r_data;
    assign status_out = r_status;
    assign flags_out  = r_flags;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// tb/tb_fpu_addsub_seq.sv - directed self-checking bench for fpu_addsub_seq.
module tb_fpu_addsub_seq;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        op_sub = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        clear = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] data;
    logic [3:0]  status;
    logic        flags;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_addsub_seq dut (
        .clock100KHz (clk),
        .reset       (resetn),
        .start_in    (start),
        .op_sub_in   (op_sub),
        .op_A_in     (op_a),
        .op_B_in     (op_b),
        .clear_in    (clear),
        .busy_out    (busy),
        .done_out    (done),
        .data_out    (data),
        .status_out  (status),
        .flags_out   (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b, input logic sub);
        @(posedge clk); #1;
        op_a = a; op_b = b; op_sub = sub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output logic [31:0] d, output logic [3:0] st,
                             output logic f);
        bit got;
        got = 0;
        d = '0; st = '0; f = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1; d = data; st = status; f = flags;
            end
        end
        chk({tag, "_done"}, 32'(got), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] exp_d, input logic [3:0] exp_st);
        logic [31:0] d;
        logic [3:0]  st;
        logic        f;
        pulse_start(a, b, sub);
        wait_done(tag, d, st, f);
        chk({tag, "_data"}, d, exp_d);
        chk({tag, "_status"}, 32'(st), 32'(exp_st));
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  st;
        logic        f;
        int          extra;
        logic [31:0] rne_exp;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_data",   data,        32'h0);
        chk("rst_status", 32'(status), 32'h0);
        chk("rst_flags",  32'(flags),  32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        pulse_start(32'h3F800000, 32'h40000000, 1'b0);
        wait_done("add_1_2", d, st, f);
        chk("add_1_2_data",   d,       32'h40400000);
        chk("add_1_2_status", 32'(st), 32'h1);
        chk("add_1_2_flags",  32'(f),  32'd0);

        run_op("sub_1_1",     32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0001);
        run_op("add_15_15",   32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0001);
        run_op("sub_1_2",     32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0001);
        run_op("add_2_m2",    32'h40000000, 32'hC0000000, 1'b0, 32'h00000000, 4'b0001);
        run_op("denorm",      32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0001);
        @(negedge clk);
        chk("flags_exact_run", 32'(flags), 32'd0);

        pulse_start(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
        wait_done("ovf", d, st, f);
        chk("ovf_data",   d,       32'h7F800000);
        chk("ovf_status", 32'(st), 32'h2);
        chk("ovf_flags",  32'(f),  32'd1);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("flags_cleared", 32'(flags), 32'd0);

        run_op("unf",     32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0100);
        @(negedge clk);
        chk("unf_flags", 32'(flags), 32'd1);
`ifdef FPU_ROUND_NEAREST_EN
        rne_exp = 32'h3F800001;
`else
        rne_exp = 32'h3F800000;
`endif
        run_op("inexact", 32'h3F800000, 32'h33C00000, 1'b0, rne_exp, 4'b1000);
        run_op("inf_a",   32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0010);
        run_op("inf_b",   32'hBF800000, 32'h7F800000, 1'b0, 32'hFF800000, 4'b0010);

        pulse_start(32'h3F800000, 32'h40000000, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("abort_busy",   32'(busy),   32'd0);
        chk("abort_data",   data,        32'h0);
        chk("abort_status", 32'(status), 32'h0);
        chk("abort_flags",  32'(flags),  32'd0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("abort_no_done", 32'(extra), 32'd0);

        pulse_start(32'h3F800000, 32'h40000000, 1'b0);
        @(negedge clk);
        chk("busy_high", 32'(busy), 32'd1);
        pulse_start(32'h7F800000, 32'h3F800000, 1'b0);
        wait_done("ign", d, st, f);
        chk("ign_data",   d,       32'h40400000);
        chk("ign_status", 32'(st), 32'h1);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("ign_no_second", 32'(extra), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
